// File: rtl/xadac_pkg.sv
// xadac_pkg: shared types and constants for the xadac vector execute block.
// Holds the vector data/address types, the custom-0 opcode and funct3
// encodings, the decode/execute request and response structs, and a small
// helper that classifies an instruction word into a vector operation.
package xadac_pkg;

  localparam int unsigned VecLen  = 64;
  localparam int unsigned IdWidth = 4;

  typedef logic [VecLen-1:0]  VecDataT;
  typedef logic [4:0]         VecAddrT;
  typedef logic [IdWidth-1:0] IdT;

  localparam logic [6:0] OpcVexe = 7'b0001011;
  localparam logic [2:0] F3Vadd  = 3'b000;
  localparam logic [2:0] F3Vmul  = 3'b001;
  localparam logic [2:0] F3Vdot  = 3'b010;

  typedef enum logic [1:0] {
    VopAdd,
    VopMul,
    VopDot,
    VopNone
  } vop_e;

  typedef struct packed {
    IdT          id;
    logic [31:0] instr;
  } dec_req_t;

  typedef struct packed {
    IdT            id;
    logic          accept;
    VecAddrT [1:0] vs_read;   // [1] = vs2, [0] = vs1
    logic          vd_write;
    logic          rd_write;
  } dec_rsp_t;

  typedef struct packed {
    IdT            id;
    logic [31:0]   instr;
    VecDataT [1:0] vs_data;   // [1] = vs2, [0] = vs1
  } exe_req_t;

  typedef struct packed {
    IdT          id;
    VecAddrT     vd_id;
    VecDataT     vd;
    logic        vd_write;
    logic [4:0]  rd_id;
    logic [31:0] rd;
    logic        rd_write;
  } exe_rsp_t;

  // Only custom-0 with funct7 == 0 and one of the three funct3 codes is a
  // supported vector op; everything else maps to VopNone.
  function automatic vop_e decode_op(input logic [31:0] instr);
    vop_e op;
    op = VopNone;
    if (instr[6:0] == OpcVexe && instr[31:25] == 7'b0000000) begin
      case (instr[14:12])
        F3Vadd:  op = VopAdd;
        F3Vmul:  op = VopMul;
        F3Vdot:  op = VopDot;
        default: op = VopNone;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/xadac_if.sv
// xadac_if: decode and execute channels between a core (mst) and a vector
// coprocessor (slv). Each channel is a valid/ready request plus a
// valid/ready response.
interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;

  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );
endinterface

// File: rtl/xadac_vexe_lane_alu.sv
// xadac_vexe_lane_alu: combinational lanewise 8-bit add or multiply.
//   is_mul : 1 = lanewise product (low 8 bits), 0 = lanewise add mod 256
//   a, b   : NoLanes packed 8-bit lanes, lane 0 in the low byte
//   y      : lanewise result
module xadac_vexe_lane_alu #(
  parameter int unsigned NoLanes = 8
) (
  input  logic                 is_mul,
  input  logic [NoLanes*8-1:0] a,
  input  logic [NoLanes*8-1:0] b,
  output logic [NoLanes*8-1:0] y
);

  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < NoLanes; i++) begin
      if (is_mul) begin
        y[i*8 +: 8] = a[i*8 +: 8] * b[i*8 +: 8];
      end else begin
        y[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/xadac_vexe.sv
// xadac_vexe: vector execute unit terminating the xadac decode and execute
// channels.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   slv      : xadac_if slave end; receives dec_req/exe_req, drives
//              dec_rsp/exe_rsp
// Decode answers one cycle after each accepted request. Execute runs
// VADD/VMUL in one cycle and VDOT as one lane product per cycle.
module xadac_vexe
  import xadac_pkg::*;
#(
  parameter int unsigned NoLanes = VecLen / 8
) (
  input  logic  clk,
  input  logic  rst,
  xadac_if.slv  slv
);

  localparam int unsigned      LaneW    = (NoLanes > 1) ? $clog2(NoLanes) : 1;
  localparam int unsigned      AluW     = NoLanes * 8;
  localparam logic [LaneW-1:0] LastLane = LaneW'(NoLanes - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDot,
    StResp
  } state_e;

  // ---------------------------------------------------------------- decode
  logic     dec_hs;
  logic     dec_rsp_valid_d, dec_rsp_valid_q;
  dec_rsp_t dec_rsp_d, dec_rsp_q;
  vop_e     dec_op;

  assign slv.dec_req_ready = !dec_rsp_valid_q || slv.dec_rsp_ready;
  assign dec_hs            = slv.dec_req_valid && slv.dec_req_ready;
  assign dec_op            = decode_op(slv.dec_req.instr);

  always_comb begin
    dec_rsp_valid_d = dec_rsp_valid_q;
    dec_rsp_d       = dec_rsp_q;
    if (dec_hs) begin
      dec_rsp_valid_d = 1'b1;
      dec_rsp_d       = '0;
      dec_rsp_d.id    = slv.dec_req.id;
      if (dec_op != VopNone) begin
        dec_rsp_d.accept     = 1'b1;
        dec_rsp_d.vs_read[1] = slv.dec_req.instr[24:20];
        dec_rsp_d.vs_read[0] = slv.dec_req.instr[19:15];
        dec_rsp_d.vd_write   = (dec_op != VopDot);
        dec_rsp_d.rd_write   = (dec_op == VopDot);
      end
    end else if (slv.dec_rsp_ready) begin
      dec_rsp_valid_d = 1'b0;
    end
  end

  assign slv.dec_rsp_valid = dec_rsp_valid_q;
  assign slv.dec_rsp       = dec_rsp_q;

  // --------------------------------------------------------------- execute
  state_e            state_d, state_q;
  logic [31:0]       acc_d, acc_q;
  logic [LaneW-1:0]  lane_d, lane_q;
  VecDataT           vs1_d, vs1_q;
  VecDataT           vs2_d, vs2_q;
  exe_rsp_t          rsp_d, rsp_q;
  logic              capture;
  vop_e              req_op;
  logic [AluW-1:0]   alu_y;
  logic [7:0]        lane_a, lane_b;
  logic [15:0]       lane_prod;
  logic [31:0]       acc_next;

  assign req_op = decode_op(slv.exe_req.instr);

  // VADD/VMUL results are computed from the request inputs and registered at
  // capture, so the response fields come straight from flops in RESP.
  xadac_vexe_lane_alu #(
    .NoLanes (NoLanes)
  ) u_lane_alu (
    .is_mul (req_op == VopMul),
    .a      (slv.exe_req.vs_data[0][AluW-1:0]),
    .b      (slv.exe_req.vs_data[1][AluW-1:0]),
    .y      (alu_y)
  );

  assign lane_a    = vs1_q[{lane_q, 3'b000} +: 8];
  assign lane_b    = vs2_q[{lane_q, 3'b000} +: 8];
  assign lane_prod = lane_a * lane_b;
  assign acc_next  = acc_q + {16'b0, lane_prod};

  assign slv.exe_req_ready = (state_q == StIdle) ||
                             (state_q == StResp && slv.exe_rsp_ready);
  assign slv.exe_rsp_valid = (state_q == StResp);
  assign slv.exe_rsp       = rsp_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    lane_d  = lane_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    rsp_d   = rsp_q;
    capture = 1'b0;

    case (state_q)
      StIdle: capture = slv.exe_req_valid;
      StDot: begin
        acc_d  = acc_next;
        lane_d = lane_q + 1'b1;
        if (lane_q == LastLane) begin
          state_d  = StResp;
          lane_d   = '0;
          rsp_d.rd = acc_next;
        end
      end
      StResp: begin
        if (slv.exe_rsp_ready) begin
          state_d = StIdle;
          capture = slv.exe_req_valid;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture overrides the RESP->IDLE transition so a request arriving with
    // the response handshake starts without a bubble.
    if (capture) begin
      vs1_d       = slv.exe_req.vs_data[0];
      vs2_d       = slv.exe_req.vs_data[1];
      acc_d       = '0;
      lane_d      = '0;
      rsp_d       = '0;
      rsp_d.id    = slv.exe_req.id;
      rsp_d.vd_id = slv.exe_req.instr[11:7];
      rsp_d.rd_id = slv.exe_req.instr[11:7];
      state_d     = StResp;
      case (req_op)
        VopAdd, VopMul: begin
          rsp_d.vd       = VecDataT'(alu_y);
          rsp_d.vd_write = 1'b1;
        end
        VopDot: begin
          rsp_d.rd_write = 1'b1;
          state_d        = StDot;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_rsp_valid_q <= 1'b0;
      dec_rsp_q       <= '0;
      state_q         <= StIdle;
      acc_q           <= '0;
      lane_q          <= '0;
      vs1_q           <= '0;
      vs2_q           <= '0;
      rsp_q           <= '0;
    end else begin
      dec_rsp_valid_q <= dec_rsp_valid_d;
      dec_rsp_q       <= dec_rsp_d;
      state_q         <= state_d;
      acc_q           <= acc_d;
      lane_q          <= lane_d;
      vs1_q           <= vs1_d;
      vs2_q           <= vs2_d;
      rsp_q           <= rsp_d;
    end
  end

endmodule

// File: tb/tb_xadac_vexe.sv
// tb_xadac_vexe: self-checking bench for xadac_vexe. Directed scenarios plus
// randomized traffic checked against a lane-by-lane arithmetic model.
module tb_xadac_vexe;
  import xadac_pkg::*;

  localparam int NL = 8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  xadac_if u_if ();

  xadac_vexe #(.NoLanes(NL)) dut (
    .clk (clk),
    .rst (rst),
    .slv (u_if.slv)
  );

  // ------------------------------------------------------------ reference
  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic bit m_supported(input logic [31:0] ins);
    return ins[6:0] == 7'b0001011 && ins[31:25] == 7'd0 && ins[14:12] <= 3'd2;
  endfunction

  function automatic logic [63:0] m_vd(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      int x, y, z;
      x = int'((a >> (8 * i)) & 64'hFF);
      y = int'((b >> (8 * i)) & 64'hFF);
      z = (f3 == 3'd1) ? (x * y) % 256 : (x + y) % 256;
      r = r | (64'(z) << (8 * i));
    end
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [63:0] a, input logic [63:0] b);
    int s;
    s = 0;
    for (int i = 0; i < NL; i++)
      s += int'((a >> (8 * i)) & 64'hFF) * int'((b >> (8 * i)) & 64'hFF);
    return 32'(s);
  endfunction

  // Presents one exe_req and returns just after the handshake edge.
  task automatic issue(input IdT id, input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b);
    int n;
    u_if.exe_req.id         = id;
    u_if.exe_req.instr      = instr;
    u_if.exe_req.vs_data[0] = a;
    u_if.exe_req.vs_data[1] = b;
    u_if.exe_req_valid      = 1'b1;
    #1;
    n = 0;
    while (!u_if.exe_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (n >= 50) begin bad++; $display("FAIL exe_req_accept got=timeout exp=ready"); end
    @(posedge clk); #1;
    u_if.exe_req_valid = 1'b0;
  endtask

  // Counts edges from the handshake edge (=1) until exe_rsp_valid shows.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!u_if.exe_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    u_if.dec_req_valid = 1'b0; u_if.dec_req = '0; u_if.dec_rsp_ready = 1'b1;
    u_if.exe_req_valid = 1'b0; u_if.exe_req = '0; u_if.exe_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (u_if.dec_req_ready !== 1'b1) begin bad++; $display("FAIL rst_dec_req_ready got=%b exp=1", u_if.dec_req_ready); end
    total++; if (u_if.exe_req_ready !== 1'b1) begin bad++; $display("FAIL rst_exe_req_ready got=%b exp=1", u_if.exe_req_ready); end
    total++; if (u_if.dec_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_rsp_valid got=%b exp=0", u_if.dec_rsp_valid); end
    total++; if (u_if.exe_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_exe_rsp_valid got=%b exp=0", u_if.exe_rsp_valid); end
    total++; if (u_if.exe_rsp !== '0) begin bad++; $display("FAIL rst_exe_rsp got=%h exp=0", u_if.exe_rsp); end
    total++; if (u_if.dec_rsp !== '0) begin bad++; $display("FAIL rst_dec_rsp got=%h exp=0", u_if.dec_rsp); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    logic [31:0] ins;
    bit sup;
    // R-type opcode is rejected
    u_if.dec_req.id = 4'd3;
    u_if.dec_req.instr = mk_instr(7'd0, 5'd2, 5'd1, 3'd0, 5'd4, 7'b0110011);
    u_if.dec_req_valid = 1'b1;
    @(posedge clk); #1;
    u_if.dec_req_valid = 1'b0;
    total++; if (u_if.dec_rsp_valid !== 1'b1) begin bad++; $display("FAIL dec_rtype_valid got=%b exp=1", u_if.dec_rsp_valid); end
    total++; if (u_if.dec_rsp.accept !== 1'b0) begin bad++; $display("FAIL dec_rtype_accept got=%b exp=0", u_if.dec_rsp.accept); end
    total++; if (u_if.dec_rsp.id !== 4'd3) begin bad++; $display("FAIL dec_rtype_id got=%0d exp=3", u_if.dec_rsp.id); end
    // VDOT is accepted as a scalar-result op
    u_if.dec_req.id = 4'd5;
    u_if.dec_req.instr = mk_instr(7'd0, 5'd9, 5'd7, 3'b010, 5'd6, 7'b0001011);
    u_if.dec_req_valid = 1'b1;
    @(posedge clk); #1;
    u_if.dec_req_valid = 1'b0;
    total++; if (u_if.dec_rsp.accept !== 1'b1) begin bad++; $display("FAIL dec_vdot_accept got=%b exp=1", u_if.dec_rsp.accept); end
    total++; if (u_if.dec_rsp.rd_write !== 1'b1) begin bad++; $display("FAIL dec_vdot_rd_write got=%b exp=1", u_if.dec_rsp.rd_write); end
    total++; if (u_if.dec_rsp.vd_write !== 1'b0) begin bad++; $display("FAIL dec_vdot_vd_write got=%b exp=0", u_if.dec_rsp.vd_write); end
    total++; if (u_if.dec_rsp.vs_read !== {5'd9, 5'd7}) begin bad++; $display("FAIL dec_vdot_vs_read got=%h exp=%h", u_if.dec_rsp.vs_read, {5'd9, 5'd7}); end
    @(posedge clk); #1;
    // Backpressure: response must hold and req_ready must drop
    u_if.dec_rsp_ready = 1'b0;
    u_if.dec_req.id = 4'd6;
    u_if.dec_req.instr = mk_instr(7'd0, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0001011);
    u_if.dec_req_valid = 1'b1;
    @(posedge clk); #1;
    u_if.dec_req.id = 4'd7;
    for (int k = 0; k < 3; k++) begin
      total++; if (u_if.dec_req_ready !== 1'b0) begin bad++; $display("FAIL dec_bp_req_ready got=%b exp=0", u_if.dec_req_ready); end
      total++; if (u_if.dec_rsp_valid !== 1'b1 || u_if.dec_rsp.id !== 4'd6) begin bad++; $display("FAIL dec_bp_hold got=%b/%0d exp=1/6", u_if.dec_rsp_valid, u_if.dec_rsp.id); end
      @(posedge clk); #1;
    end
    u_if.dec_rsp_ready = 1'b1;
    #1;
    total++; if (u_if.dec_req_ready !== 1'b1) begin bad++; $display("FAIL dec_bp_release got=%b exp=1", u_if.dec_req_ready); end
    @(posedge clk); #1;
    u_if.dec_req_valid = 1'b0;
    total++; if (u_if.dec_rsp_valid !== 1'b1 || u_if.dec_rsp.id !== 4'd7) begin bad++; $display("FAIL dec_bp_next got=%b/%0d exp=1/7", u_if.dec_rsp_valid, u_if.dec_rsp.id); end
    @(posedge clk); #1;
    // Random instruction words
    for (int k = 0; k < 20; k++) begin
      ins = mk_instr(($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0, 5'($urandom), 5'($urandom),
                     3'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'b0001011);
      sup = m_supported(ins);
      u_if.dec_req.id = 4'(k);
      u_if.dec_req.instr = ins;
      u_if.dec_req_valid = 1'b1;
      @(posedge clk); #1;
      u_if.dec_req_valid = 1'b0;
      total++;
      if (u_if.dec_rsp.accept !== sup || u_if.dec_rsp.vd_write !== (sup && ins[14:12] != 3'd2) ||
          u_if.dec_rsp.rd_write !== (sup && ins[14:12] == 3'd2) || u_if.dec_rsp.id !== 4'(k)) begin
        bad++; $display("FAIL dec_rand instr=%h got acc/vd/rd=%b%b%b exp acc=%b", ins,
                        u_if.dec_rsp.accept, u_if.dec_rsp.vd_write, u_if.dec_rsp.rd_write, sup);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vadd();
    int lat;
    u_if.exe_rsp_ready = 1'b1;
    issue(4'd1, mk_instr(7'd0, 5'd2, 5'd1, 3'b000, 5'd13, 7'b0001011),
          64'h0102030405060708, 64'hFF01010101010101);
    wait_rsp(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL vadd_latency got=%0d exp=1", lat); end
    total++; if (u_if.exe_rsp.vd !== 64'h0003040506070809) begin bad++; $display("FAIL vadd_vd got=%h exp=0003040506070809", u_if.exe_rsp.vd); end
    total++; if (u_if.exe_rsp.vd_write !== 1'b1 || u_if.exe_rsp.rd_write !== 1'b0) begin bad++; $display("FAIL vadd_writes got=%b%b exp=10", u_if.exe_rsp.vd_write, u_if.exe_rsp.rd_write); end
    total++; if (u_if.exe_rsp.vd_id !== 5'd13 || u_if.exe_rsp.id !== 4'd1) begin bad++; $display("FAIL vadd_ids got=%0d/%0d exp=13/1", u_if.exe_rsp.vd_id, u_if.exe_rsp.id); end
    @(posedge clk); #1;
    total++; if (u_if.exe_rsp_valid !== 1'b0) begin bad++; $display("FAIL vadd_single got=%b exp=0", u_if.exe_rsp_valid); end
  endtask

  task automatic test_vdot();
    int lat;
    u_if.exe_rsp_ready = 1'b1;
    issue(4'd2, mk_instr(7'd0, 5'd4, 5'd3, 3'b010, 5'd10, 7'b0001011),
          64'h0202020202020202, 64'h0303030303030303);
    lat = 1;
    while (!u_if.exe_rsp_valid && lat < 40) begin
      total++; if (u_if.exe_req_ready !== 1'b0) begin bad++; $display("FAIL vdot_busy_ready got=%b exp=0 at=%0d", u_if.exe_req_ready, lat); end
      @(posedge clk); #1; lat++;
    end
    total++; if (lat !== NL + 1) begin bad++; $display("FAIL vdot_latency got=%0d exp=%0d", lat, NL + 1); end
    total++; if (u_if.exe_rsp.rd !== 32'd48) begin bad++; $display("FAIL vdot_rd got=%0d exp=48", u_if.exe_rsp.rd); end
    total++; if (u_if.exe_rsp.rd_write !== 1'b1 || u_if.exe_rsp.vd_write !== 1'b0) begin bad++; $display("FAIL vdot_writes got=%b%b exp=10", u_if.exe_rsp.rd_write, u_if.exe_rsp.vd_write); end
    total++; if (u_if.exe_rsp.rd_id !== 5'd10 || u_if.exe_rsp.id !== 4'd2) begin bad++; $display("FAIL vdot_ids got=%0d/%0d exp=10/2", u_if.exe_rsp.rd_id, u_if.exe_rsp.id); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat, cnt;
    logic [63:0] a, b, exp_vd;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp_vd = m_vd(3'b001, a, b);
    u_if.exe_rsp_ready = 1'b0;
    issue(4'd9, mk_instr(7'd0, 5'd5, 5'd6, 3'b001, 5'd17, 7'b0001011), a, b);
    wait_rsp(lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL vmul_latency got=%0d exp=1", lat); end
    u_if.exe_req.id = 4'd10;
    u_if.exe_req_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (u_if.exe_rsp_valid !== 1'b1 || u_if.exe_rsp.vd !== exp_vd || u_if.exe_rsp.id !== 4'd9) begin bad++; $display("FAIL vmul_hold got=%b/%h exp=1/%h", u_if.exe_rsp_valid, u_if.exe_rsp.vd, exp_vd); end
      total++; if (u_if.exe_req_ready !== 1'b0) begin bad++; $display("FAIL vmul_bp_req_ready got=%b exp=0", u_if.exe_req_ready); end
      @(posedge clk); #1;
    end
    u_if.exe_req_valid = 1'b0;
    u_if.exe_rsp_ready = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (u_if.exe_rsp_valid) cnt++;
      @(posedge clk); #1;
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL vmul_extra_rsp got=%0d exp=0", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a0, b0, a1, b1;
    a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    u_if.exe_rsp_ready = 1'b1;
    issue(4'd11, mk_instr(7'd0, 5'd1, 5'd2, 3'b000, 5'd20, 7'b0001011), a0, b0);
    u_if.exe_req.id = 4'd12;
    u_if.exe_req.instr = mk_instr(7'd0, 5'd3, 5'd4, 3'b000, 5'd21, 7'b0001011);
    u_if.exe_req.vs_data[0] = a1;
    u_if.exe_req.vs_data[1] = b1;
    u_if.exe_req_valid = 1'b1;
    #1;
    total++; if (u_if.exe_rsp_valid !== 1'b1 || u_if.exe_rsp.id !== 4'd11 || u_if.exe_rsp.vd !== m_vd(3'd0, a0, b0)) begin bad++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/11/%h", u_if.exe_rsp_valid, u_if.exe_rsp.id, u_if.exe_rsp.vd, m_vd(3'd0, a0, b0)); end
    total++; if (u_if.exe_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_req_ready got=%b exp=1", u_if.exe_req_ready); end
    @(posedge clk); #1;
    u_if.exe_req_valid = 1'b0;
    total++; if (u_if.exe_rsp_valid !== 1'b1 || u_if.exe_rsp.id !== 4'd12 || u_if.exe_rsp.vd !== m_vd(3'd0, a1, b1)) begin bad++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/12/%h", u_if.exe_rsp_valid, u_if.exe_rsp.id, u_if.exe_rsp.vd, m_vd(3'd0, a1, b1)); end
    total++; if (u_if.exe_rsp.vd_id !== 5'd21) begin bad++; $display("FAIL b2b_vd_id got=%0d exp=21", u_if.exe_rsp.vd_id); end
    @(posedge clk); #1;
    total++; if (u_if.exe_rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", u_if.exe_rsp_valid); end
  endtask

  task automatic test_reset_mid_dot();
    int cnt, lat;
    u_if.exe_rsp_ready = 1'b1;
    issue(4'd13, mk_instr(7'd0, 5'd1, 5'd2, 3'b010, 5'd8, 7'b0001011),
          {$urandom, $urandom}, {$urandom, $urandom});
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (u_if.exe_req_ready !== 1'b1) begin bad++; $display("FAIL rstdot_idle got=%b exp=1", u_if.exe_req_ready); end
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (u_if.exe_rsp_valid) cnt++;
      @(posedge clk); #1;
    end
    total++; if (cnt !== 0) begin bad++; $display("FAIL rstdot_dropped got=%0d exp=0", cnt); end
    issue(4'd14, mk_instr(7'd0, 5'd1, 5'd2, 3'b000, 5'd9, 7'b0001011),
          64'h0102030405060708, 64'hFF01010101010101);
    wait_rsp(lat);
    total++; if (lat !== 1 || u_if.exe_rsp.vd !== 64'h0003040506070809 || u_if.exe_rsp.id !== 4'd14) begin bad++; $display("FAIL rstdot_vadd got=%0d/%h/%0d exp=1/0003040506070809/14", lat, u_if.exe_rsp.vd, u_if.exe_rsp.id); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, stall, sel;
    logic [31:0] ins, dins;
    logic [63:0] a, b;
    logic [2:0] f3;
    logic [6:0] f7;
    bit sup, dsup;
    IdT id;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      f7 = 7'd0;
      if (sel == 3) begin
        f3 = 3'($urandom_range(3, 7));
        if ($urandom_range(0, 1) == 1) begin f3 = 3'($urandom_range(0, 2)); f7 = 7'($urandom_range(1, 127)); end
      end else f3 = 3'(sel);
      ins = mk_instr(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0001011);
      sup = m_supported(ins);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      id = 4'($urandom);
      stall = $urandom_range(0, 3);
      dins = mk_instr(7'd0, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                      ($urandom_range(0, 1) == 1) ? 7'b0001011 : 7'($urandom));
      dsup = m_supported(dins);
      u_if.dec_req.id = ~id;
      u_if.dec_req.instr = dins;
      u_if.dec_req_valid = 1'b1;
      u_if.exe_rsp_ready = (stall == 0);
      issue(id, ins, a, b);
      u_if.dec_req_valid = 1'b0;
      total++; if (u_if.dec_rsp_valid !== 1'b1 || u_if.dec_rsp.id !== ~id || u_if.dec_rsp.accept !== dsup) begin bad++; $display("FAIL rand_dec got=%b/%0d/%b exp=1/%0d/%b", u_if.dec_rsp_valid, u_if.dec_rsp.id, u_if.dec_rsp.accept, ~id, dsup); end
      wait_rsp(lat);
      total++; if (lat !== ((sup && f3 == 3'd2) ? NL + 1 : 1)) begin bad++; $display("FAIL rand_latency instr=%h got=%0d", ins, lat); end
      total++;
      if (u_if.exe_rsp.id !== id || u_if.exe_rsp.vd_id !== ins[11:7] || u_if.exe_rsp.rd_id !== ins[11:7] ||
          u_if.exe_rsp.vd_write !== (sup && f3 != 3'd2) || u_if.exe_rsp.rd_write !== (sup && f3 == 3'd2)) begin
        bad++; $display("FAIL rand_fields instr=%h got id=%0d vdw=%b rdw=%b exp id=%0d sup=%b", ins,
                        u_if.exe_rsp.id, u_if.exe_rsp.vd_write, u_if.exe_rsp.rd_write, id, sup);
      end
      if (sup && f3 != 3'd2) begin
        total++; if (u_if.exe_rsp.vd !== m_vd(f3, a, b)) begin bad++; $display("FAIL rand_vd got=%h exp=%h", u_if.exe_rsp.vd, m_vd(f3, a, b)); end
      end
      if (sup && f3 == 3'd2) begin
        total++; if (u_if.exe_rsp.rd !== m_rd(a, b)) begin bad++; $display("FAIL rand_rd got=%0d exp=%0d", u_if.exe_rsp.rd, m_rd(a, b)); end
      end
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        total++; if (u_if.exe_rsp_valid !== 1'b1 || u_if.exe_rsp.id !== id) begin bad++; $display("FAIL rand_hold got=%b/%0d exp=1/%0d", u_if.exe_rsp_valid, u_if.exe_rsp.id, id); end
      end
      u_if.exe_rsp_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (u_if.exe_rsp_valid !== 1'b0) begin bad++; $display("FAIL rand_single got=%b exp=0", u_if.exe_rsp_valid); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_decode();
    test_vadd();
    test_vdot();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_dot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xadac_vexe.md
XADAC_VEXE -- requirements
Module: xadac_vexe

Interface
REQ-001 SHALL have parameter NoLanes, default VecLen/8: number of 8-bit lanes per vector.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port slv  xadac_if.slv  --  terminating end of the xadac decode and execute channels.
REQ-005 SHALL be the responder for the xadac interface: it receives dec_req and exe_req, and it drives dec_rsp and exe_rsp.

Function
REQ-006 SHALL accept only instructions with opcode 0001011 (custom-0) and funct7=0.
- funct3 000 = VADD: lanewise add mod 256.
- funct3 001 = VMUL: lanewise product, low 8 bits.
- funct3 010 = VDOT: 32-bit sum of the 8x8 unsigned lane products.
REQ-007 Decode SHALL register its response.
- dec_req accepted at cycle N gives dec_rsp_valid at N+1, with the same id.
- dec_rsp.accept=1 only for a supported op.
- vs_read = {vs2, vs1} for all three ops.
- vd_write=1 for VADD/VMUL; rd_write=1 for VDOT.
REQ-008 dec_req_ready SHALL equal !dec_rsp_valid || dec_rsp_ready; dec_rsp SHALL hold stable while valid and not ready.
REQ-009 Execute SHALL be an FSM with states IDLE, DOT, RESP.
REQ-010 exe_req_ready SHALL be 1 in IDLE, or in RESP with exe_rsp_ready=1; in DOT it SHALL be 0.
REQ-011 On an exe_req handshake the FSM SHALL capture id, instr, vs_data[0] (vs1) and vs_data[1] (vs2).
- VADD/VMUL go to RESP next cycle (latency 1).
- VDOT goes to DOT.
REQ-012 DOT SHALL add one lane product per cycle, lane 0 first, using a lane counter 0..NoLanes-1 into a 32-bit accumulator cleared on capture.
- After NoLanes DOT cycles it goes to RESP.
- VDOT latency is NoLanes+1.
REQ-013 In RESP, exe_rsp_valid=1, and exe_rsp SHALL carry: id; vd_id=instr[11:7]; vd; vd_write; rd_id=instr[11:7]; rd; rd_write.
- All fields stable until handshake.
REQ-014 On an exe_rsp handshake the FSM SHALL go to IDLE, or directly capture a new request when exe_req_valid=1 in the same cycle (back-to-back, no bubble).
REQ-015 An unsupported instr reaching execute SHALL respond after 1 cycle with vd_write=0, rd_write=0.
REQ-016 Responses SHALL be issued in acceptance order; exactly one exe_rsp per accepted exe_req.
REQ-017 Decode and execute channels SHALL operate independently; simultaneous handshakes on both SHALL be legal.

Reset
REQ-018 While rst=1, the block SHALL hold:
- FSM = IDLE
- dec_rsp_valid=0, exe_rsp_valid=0
- dec_req_ready=1, exe_req_ready=1
- accumulator and lane counter = 0
- all registered rsp fields = 0
REQ-019 Reset asserted mid-VDOT or in RESP SHALL drop the pending response without emitting it.

Structure
REQ-020 xadac_pkg SHALL hold:
- VecLen=64
- the VecDataT and VecAddrT types
- opcode/funct3 constants (OpcVexe, F3Vadd, F3Vmul, F3Vdot)
- the dec_rsp and exe_rsp struct typedefs
REQ-021 The lanewise VADD/VMUL datapath SHALL be a combinational sub-module xadac_vexe_lane_alu, instantiated once.

Verification
REQ-022 VADD: vs1=0x0102030405060708, vs2=0xFF01010101010101 -> exe_rsp at N+1 with vd=0x0003040506070809, vd_write=1, vd_id=instr[11:7].
REQ-023 VDOT: vs1=0x0202020202020202, vs2=0x0303030303030303 -> exe_rsp at N+9 with rd=48, rd_write=1; exe_req_ready=0 during cycles N+1..N+8.
REQ-024 Backpressure: VMUL response with exe_rsp_ready=0 for 5 cycles -> response held stable and exe_req_ready=0; then one response only.
REQ-025 Back-to-back: two VADDs presented with exe_rsp_ready=1 -> responses on consecutive cycles, in order, ids matching.
REQ-026 Decode: opcode 0110011 -> dec_rsp.accept=0 at N+1; funct3 010 with custom-0 -> accept=1, rd_write=1, vd_write=0.
REQ-027 Reset: rst pulsed at DOT lane 4 -> no exe_rsp emitted, IDLE next cycle, a new VADD completes correctly.
